ssd_share_arbiter: RTL and testbench

Round-robin arbiter that shares the board's single 4-digit seven-segment display between three independent requesters. Each requester presents a 16-bit value as four hex nibbles. The arbiter grants the display to one requester at a time and enforces a minimum dwell so every grant stays readable. It drives the `thousands`/`hundreds`/`tens`/`ones` digit inputs of the display scan/decode block that sits directly downstream.

---
 rtl/ssd_share_arbiter.sv | 158 +++++++++++++++
 tb/tb_ssd_share_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd_share_arbiter.sv
// ssd_share_arbiter: round-robin owner of the shared 4-digit seven-segment display.
// Ports: clk, reset (sync, active-high), req[2:0], value0..2[15:0] in;
//        grant[2:0], switch_pulse, active, thousands/hundreds/tens/ones[3:0] out (all registered).
module ssd_share_arbiter #(
    parameter int unsigned DWELL      = 100_000_000,
    parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] value0,
    input  logic [15:0] value1,
    input  logic [15:0] value2,
    output logic [2:0]  grant,
    output logic        switch_pulse,
    output logic        active,
    output logic [3:0]  thousands,
    output logic [3:0]  hundreds,
    output logic [3:0]  tens,
    output logic [3:0]  ones
);

    localparam int unsigned   CW     = $clog2(DWELL) + 1;
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_OPEN
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    grant_q, grant_d;
    logic          pulse_q, pulse_d;
    logic          active_q;
    logic [15:0]   digits_q, digits_d;

    logic          open_eval;
    logic          do_grant;
    logic [1:0]    win;
    logic [2:0]    others;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] x);
        return 3'b001 << x;
    endfunction

    // First set bit of m in the order base+1, base+2, base (mod 3).
    // Callers only use the result when m is nonzero.
    function automatic logic [1:0] pick(input logic [1:0] base,
                                        input logic [2:0] m);
        logic [1:0] a;
        logic [1:0] b;
        a = inc3(base);
        b = inc3(a);
        if (m[a])      return a;
        else if (m[b]) return b;
        else           return base;
    endfunction

    // While a grant is held, last_q is the current owner.
    assign others = req & ~onehot(last_q);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        pulse_d   = 1'b0;
        open_eval = 1'b0;
        do_grant  = 1'b0;
        win       = last_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                    win      = pick(last_q, req);
                end
            end
            S_DWELL: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             open_eval = 1'b1;
            end
            S_OPEN: open_eval = 1'b1;
            default: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
            end
        endcase

        // Competitors beat the owner; owner keeps it only if nobody else asks.
        if (open_eval) begin
            if (|others) begin
                do_grant = 1'b1;
                win      = pick(last_q, others);
            end else if (req[last_q]) begin
                state_d = S_OPEN;
            end else begin
                state_d = S_IDLE;
                grant_d = 3'b000;
            end
        end

        if (do_grant) begin
            last_d  = win;
            grant_d = onehot(win);
            cnt_d   = RELOAD;
            state_d = S_DWELL;
            pulse_d = 1'b1;
        end
    end

    // Digits follow the next-state owner so they change on the grant edge.
    always_comb begin
        digits_d = IDLE_VALUE;
        case (grant_d)
            3'b001:  digits_d = value0;
            3'b010:  digits_d = value1;
            3'b100:  digits_d = value2;
            default: digits_d = IDLE_VALUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            last_q   <= 2'd2;
            cnt_q    <= '0;
            grant_q  <= 3'b000;
            pulse_q  <= 1'b0;
            active_q <= 1'b0;
            digits_q <= IDLE_VALUE;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            pulse_q  <= pulse_d;
            active_q <= |grant_d;
            digits_q <= digits_d;
        end
    end

    assign grant        = grant_q;
    assign switch_pulse = pulse_q;
    assign active       = active_q;
    assign thousands    = digits_q[15:12];
    assign hundreds     = digits_q[11:8];
    assign tens         = digits_q[7:4];
    assign ones         = digits_q[3:0];

endmodule

// File: tb/tb_ssd_share_arbiter.sv
// tb_ssd_share_arbiter: directed vector table plus randomized run
// against a behavioural owner/age model of the display arbiter.
module tb_ssd_share_arbiter;

    localparam int unsigned DW   = 4;
    localparam logic [15:0] IDLV = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [15:0] value0, value1, value2;
    logic [2:0]  grant;
    logic        switch_pulse, active;
    logic [3:0]  thousands, hundreds, tens, ones;

    int checks   = 0;
    int failures = 0;

    ssd_share_arbiter #(.DWELL(DW), .IDLE_VALUE(IDLV)) dut (
        .clk(clk), .reset(reset), .req(req),
        .value0(value0), .value1(value1), .value2(value2),
        .grant(grant), .switch_pulse(switch_pulse), .active(active),
        .thousands(thousands), .hundreds(hundreds), .tens(tens), .ones(ones)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (-1 = none), edges since grant, last grantee.
    int          m_owner;
    int          m_last;
    int          m_age;
    logic        m_pulse;

    function automatic logic [15:0] val_of(input int i);
        if (i == 0) return value0;
        if (i == 1) return value1;
        return value2;
    endfunction

    task automatic model_step();
        bit found;
        int cand;
        m_pulse = 1'b0;
        if (reset) begin
            m_owner = -1;
            m_last  = 2;
            m_age   = 0;
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= 3; k++) begin
                cand = (m_last + k) % 3;
                if (!found && req[cand]) begin
                    found   = 1;
                    m_owner = cand;
                    m_last  = cand;
                    m_age   = 0;
                    m_pulse = 1'b1;
                end
            end
        end else begin
            if (m_age < DW) m_age++;
            if (m_age >= DW) begin
                found = 0;
                for (int k = 1; k <= 2; k++) begin
                    cand = (m_owner + k) % 3;
                    if (!found && req[cand]) begin
                        found   = 1;
                        m_owner = cand;
                        m_last  = cand;
                        m_age   = 0;
                        m_pulse = 1'b1;
                    end
                end
                if (!found && !req[m_owner]) m_owner = -1;
            end
        end
    endtask

    function automatic logic [20:0] model_vec();
        logic [2:0]  g;
        logic [15:0] d;
        g = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
        d = (m_owner < 0) ? IDLV : val_of(m_owner);
        return {g, m_pulse, |g, d};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {grant, switch_pulse, active, thousands, hundreds, tens, ones};
    endfunction

    // Digits in the model are taken at the edge; capture them there.
    logic [20:0] m_exp;

    task automatic tick();
        @(posedge clk);
        model_step();
        m_exp = model_vec();
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [20:0] got,
                       input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got g=%b p=%b a=%b d=%h expected g=%b p=%b a=%b d=%h",
                     name, got[20:18], got[17], got[16], got[15:0],
                     exp[20:18], exp[17], exp[16], exp[15:0]);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  rq;
        logic [15:0] v0, v1, v2;
        logic [2:0]  eg;
        logic        ep;
        logic [15:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [2:0] rq,
                                input logic [15:0] v0, input logic [15:0] v1,
                                input logic [15:0] v2, input logic [2:0] eg,
                                input logic ep, input logic [15:0] ed);
        vec_t r;
        r.rst = rst; r.rq = rq; r.v0 = v0; r.v1 = v1; r.v2 = v2;
        r.eg = eg; r.ep = ep; r.ed = ed;
        return r;
    endfunction

    initial begin
        logic [20:0] ev;

        // reset values
        tbl.push_back(mk(1, 3'b000, 16'h1234, 0, 0, 3'b000, 0, 16'h0000));
        tbl.push_back(mk(1, 3'b000, 16'h1234, 0, 0, 3'b000, 0, 16'h0000));
        // single requester, early release
        tbl.push_back(mk(0, 3'b001, 16'h1234, 0, 0, 3'b001, 1, 16'h1234));
        tbl.push_back(mk(0, 3'b000, 16'h1234, 0, 0, 3'b001, 0, 16'h1234));
        tbl.push_back(mk(0, 3'b000, 16'h1234, 0, 0, 3'b001, 0, 16'h1234));
        tbl.push_back(mk(0, 3'b000, 16'h1234, 0, 0, 3'b001, 0, 16'h1234));
        tbl.push_back(mk(0, 3'b000, 16'h1234, 0, 0, 3'b000, 0, 16'h0000));
        // full contention after reset
        tbl.push_back(mk(1, 3'b111, 16'h1111, 16'h2222, 16'h3333, 3'b000, 0, 16'h0000));
        for (int r = 0; r < 4; r++) begin
            logic [2:0]  g;
            logic [15:0] d;
            g = (r == 1) ? 3'b010 : (r == 2) ? 3'b100 : 3'b001;
            d = (r == 1) ? 16'h2222 : (r == 2) ? 16'h3333 : 16'h1111;
            for (int c = 0; c < 4; c++)
                tbl.push_back(mk(0, 3'b111, 16'h1111, 16'h2222, 16'h3333,
                                 g, (c == 0), d));
        end
        // live value tracking on owner 1
        tbl.push_back(mk(1, 3'b000, 16'h1111, 16'h1234, 0, 3'b000, 0, 16'h0000));
        tbl.push_back(mk(0, 3'b010, 16'h1111, 16'h1234, 0, 3'b010, 1, 16'h1234));
        tbl.push_back(mk(0, 3'b010, 16'h1111, 16'hABCD, 0, 3'b010, 0, 16'hABCD));
        // reset mid-dwell, then requester 0 wins
        tbl.push_back(mk(1, 3'b111, 16'h1111, 16'hABCD, 0, 3'b000, 0, 16'h0000));
        tbl.push_back(mk(0, 3'b111, 16'h1111, 16'hABCD, 0, 3'b001, 1, 16'h1111));

        reset  = 1'b1;
        req    = 3'b000;
        value0 = 16'h0;
        value1 = 16'h0;
        value2 = 16'h0;
        m_owner = -1; m_last = 2; m_age = 0; m_pulse = 0;

        foreach (tbl[i]) begin
            reset  = tbl[i].rst;
            req    = tbl[i].rq;
            value0 = tbl[i].v0;
            value1 = tbl[i].v1;
            value2 = tbl[i].v2;
            tick();
            ev = {tbl[i].eg, tbl[i].ep, |tbl[i].eg, tbl[i].ed};
            chk($sformatf("vec%0d", i), dut_vec(), ev);
        end

        // held owner past dwell, then late competitor switches directly
        reset = 1'b1; req = 3'b000;
        value0 = 16'h0F0F; value1 = 16'h5A5A; value2 = 16'hC3C3;
        tick();
        reset = 1'b0; req = 3'b001;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("held_owner", dut_vec(), m_exp);
        end
        chk("held_fixed", dut_vec(), {3'b001, 1'b0, 1'b1, 16'h0F0F});
        req = 3'b101;
        tick();
        chk("late_comp", dut_vec(), {3'b100, 1'b1, 1'b1, 16'hC3C3});
        // owner drops on the same edge a competitor rises after expiry
        req = 3'b100;
        for (int c = 0; c < 4; c++) tick();
        req = 3'b010;
        tick();
        chk("drop_swap", dut_vec(), {3'b010, 1'b1, 1'b1, 16'h5A5A});

        // randomized run against the model
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) == 0) req = 3'($urandom);
            if ($urandom_range(0, 3) == 0) value0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value1 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) value2 = 16'($urandom);
            tick();
            chk("rand", dut_vec(), m_exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
